// File: rtl/data_ram_slave.sv
// Single-port data-memory responder: accepts one byte-laned word request at a time,
// inserts WAIT_CYCLES wait states, then completes with a one-cycle ack (err_o on bad address).
module data_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_data_q;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]           lane_mask;
  logic                  out_of_range;
  logic                  mem_we;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (ce) begin
          addr_d  = addr[31:2];
          we_d    = we;
          sel_d   = sel;
          wdata_d = data_i;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_of_range = |addr_q[31:ADDR_WIDTH+2];
  assign wr_idx       = addr_q[ADDR_WIDTH+1:2];
  // In IDLE the read is launched from the live bus address so the registered
  // read data is already valid in RESP even with zero wait states.
  assign rd_idx       = (state_q == IDLE) ? addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
  assign mem_we       = (state_q == RESP) && we_q && !out_of_range && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
    rd_data_q <= mem[rd_idx];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{sel_q[gi]}};
  end

  always_comb begin
    ack_o  = 1'b0;
    err_o  = 1'b0;
    data_o = 32'd0;
    if (state_q == RESP) begin
      ack_o = 1'b1;
      err_o = out_of_range;
      if (!out_of_range && !we_q) begin
        data_o = rd_data_q & lane_mask;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_slave.sv
// Directed bench for data_ram_slave: instance 0 uses two wait states, instance 1 zero;
// expected values are hand-computed constants.
module tb_data_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce   [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [3:0]  sel  [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        ack  [2];
  logic        err  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
    .data_i(din[0]), .data_o(dout[0]), .ack_o(ack[0]), .err_o(err[0])
  );

  data_ram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
    .data_i(din[1]), .data_o(dout[1]), .ack_o(ack[1]), .err_o(err[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request on instance d; inputs are scrambled after acceptance
  // so the response must come from the latched copy.
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, input logic [31:0] exp_data,
                      input logic exp_err, input string tag);
    int n;
    int lat;
    lat = (d == 0) ? 3 : 1;
    @(negedge clk);
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = wd;
    @(posedge clk);
    #1;
    ce[d] = 1'b0; we[d] = ~w; addr[d] = 32'h0000_0FFC; sel[d] = ~s; din[d] = 32'hFFFF_FFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[d] && n < 20);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " err"}, 64'(err[d]), 64'(exp_err));
    check({tag, " data"}, 64'(dout[d]), 64'(exp_data));
    @(negedge clk);
    check({tag, " ack_drop"}, 64'(ack[d]), 64'd0);
    $display("xact %s dut=%0d we=%0b addr=%h sel=%h latency=%0d data_o=%h err_o=%0b",
             tag, d, w, a, s, n, dout[d], err[d]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; sel[i] = 4'd0; din[i] = 32'd0;
    end

    // Reset then idle
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("reset_idle_w2", {30'd0, ack[0], err[0], dout[0]}, 64'd0);
      check("reset_idle_w0", {30'd0, ack[1], err[1], dout[1]}, 64'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full word, then byte lanes
    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "w10_full");
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, "r10_full");
    xact(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 32'h0, 1'b0, "w10_lanes");
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDE22BE44, 1'b0, "r10_merged");
    xact(0, 1'b0, 32'h10, 4'b1000, 32'h0, 32'hDE000000, 1'b0, "r10_lane3");
    xact(0, 1'b1, 32'h10, 4'b0000, 32'h55555555, 32'h0, 1'b0, "w10_nosel");
    xact(0, 1'b0, 32'h13, 4'hF, 32'h0, 32'hDE22BE44, 1'b0, "r10_unchanged");

    // Out of range must not alias onto word 0
    xact(0, 1'b1, 32'h0, 4'hF, 32'h01234567, 32'h0, 1'b0, "w0_prior");
    xact(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, "w1000_oor");
    xact(0, 1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1, "r1000_oor");
    xact(0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h01234567, 1'b0, "r0_noalias");

    // Zero wait states, back-to-back with ce held high
    xact(1, 1'b1, 32'h0, 4'hF, 32'hA5A50000, 32'h0, 1'b0, "w0_z");
    xact(1, 1'b1, 32'h4, 4'hF, 32'h5A5A0004, 32'h0, 1'b0, "w4_z");
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; sel[1] = 4'hF;
    @(posedge clk);
    #1 addr[1] = 32'h4;
    @(negedge clk);
    check("b2b_n1_ack", 64'(ack[1]), 64'd1);
    check("b2b_n1_data", 64'(dout[1]), 64'hA5A50000);
    @(negedge clk);
    check("b2b_n2_idle", 64'(ack[1]), 64'd0);
    @(posedge clk);
    #1 ce[1] = 1'b0;
    @(negedge clk);
    check("b2b_n3_ack", 64'(ack[1]), 64'd1);
    check("b2b_n3_data", 64'(dout[1]), 64'h5A5A0004);
    @(negedge clk);
    check("b2b_n4_ack", 64'(ack[1]), 64'd0);
    $display("xact b2b dut=1 reads 0x0 then 0x4 with ce held");

    // Reset during WAIT abandons the write
    xact(0, 1'b1, 32'h20, 4'hF, 32'h11111111, 32'h0, 1'b0, "w20_prior");
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; sel[0] = 4'hF; din[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1 ce[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_ack_during", 64'(ack[0]), 64'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_ack_after", 64'(ack[0]), 64'd0);
    end
    $display("xact rst_mid dut=0 write 0x20 abandoned by reset");
    xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11111111, 1'b0, "r20_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
